alu_cmd_ctrl: RTL

- Command-side controller that feeds the system ALU and returns its result.
- Accepts a byte stream of command frames from the receive path, assembles operands and the function code, and drives the ALU request interface (A, B, ALU_FUN, EN).
- Captures the 2*DATA_WIDTH result and returns it LSB-first as a byte stream with valid/ready handshake toward the transmit path.
- Sits between the RX deserializer and the ALU / TX serializer in the reference clock domain.

---
 rtl/alu_ctrl_pkg.sv | 33 +++
 rtl/alu_cmd_tx_mux.sv | 56 +++++
 rtl/alu_cmd_ctrl.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/alu_ctrl_pkg.sv
// Shared definitions for the ALU command controller: FSM states, frame
// opcodes, the error response byte and the ALU function codes.
// ALU_CMD_CTRL_ERR_RESP_EN adds the TX_ERR state used for error responses.
package alu_ctrl_pkg;

  localparam logic [7:0] OPC_ALU_OPER  = 8'hCC;
  localparam logic [7:0] OPC_ALU_NOPER = 8'hDD;
  localparam logic [7:0] ERR_BYTE      = 8'hEE;

  localparam logic [3:0] FUN_ADD = 4'b0000;
  localparam logic [3:0] FUN_SUB = 4'b0001;
  localparam logic [3:0] FUN_MUL = 4'b0010;
  localparam logic [3:0] FUN_DIV = 4'b0011;
  localparam logic [3:0] FUN_AND = 4'b0100;
  localparam logic [3:0] FUN_OR  = 4'b0101;
  localparam logic [3:0] FUN_XOR = 4'b0110;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_GET_A,
    ST_GET_B,
    ST_GET_FUN,
    ST_ALU_REQ,
    ST_ALU_WAIT,
    ST_TX_LSB,
    ST_TX_MSB
`ifdef ALU_CMD_CTRL_ERR_RESP_EN
    ,
    ST_TX_ERR
`endif
  } state_t;

endpackage

// File: rtl/alu_cmd_tx_mux.sv
// Result register and LSB/MSB byte selector for the transmit side.
// Holds TX_VALID/TX_DATA until the downstream accepts each byte.
// ALU_CMD_CTRL_ERR_RESP_EN adds a single-byte error response load.
module alu_cmd_tx_mux
  import alu_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      load_res,
`ifdef ALU_CMD_CTRL_ERR_RESP_EN
  input  logic                      load_err,
`endif
  input  logic [2*DATA_WIDTH-1:0]   res_in,
  input  logic                      tx_ready,
  output logic [DATA_WIDTH-1:0]     tx_data,
  output logic                      tx_valid
);

  logic [2*DATA_WIDTH-1:0] result;
  logic                    msb_sel;

  // Load a new response, then step LSB -> MSB -> done on each handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result   <= '0;
      msb_sel  <= 1'b0;
      tx_valid <= 1'b0;
    end else if (load_res) begin
      result   <= res_in;
      msb_sel  <= 1'b0;
      tx_valid <= 1'b1;
`ifdef ALU_CMD_CTRL_ERR_RESP_EN
    end else if (load_err) begin
      // Error byte goes in the upper half with msb_sel set, so it is sent
      // as a lone "last" byte through the same handshake path.
      result   <= {DATA_WIDTH'(ERR_BYTE), {DATA_WIDTH{1'b0}}};
      msb_sel  <= 1'b1;
      tx_valid <= 1'b1;
`endif
    end else if (tx_valid && tx_ready) begin
      if (msb_sel) begin
        tx_valid <= 1'b0;
      end else begin
        msb_sel <= 1'b1;
      end
    end
  end

  // Byte select straight from registered state.
  always_comb begin
    tx_data = msb_sel ? result[2*DATA_WIDTH-1:DATA_WIDTH] : result[DATA_WIDTH-1:0];
  end

endmodule

// File: rtl/alu_cmd_ctrl.sv
// Command-side ALU controller: parses CC/DD command frames from the RX byte
// stream, drives the ALU request, waits ALU_LAT cycles and returns the
// 2*DATA_WIDTH result LSB-first on the TX valid/ready stream.
// ALU_CMD_CTRL_ERR_RESP_EN: unknown opcodes answer with a single 8'hEE byte.
module alu_cmd_ctrl
  import alu_ctrl_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH   = 8,
  parameter int unsigned           ALU_LAT      = 1,
  parameter logic [DATA_WIDTH-1:0] OP_ALU_OPER  = DATA_WIDTH'(OPC_ALU_OPER),
  parameter logic [DATA_WIDTH-1:0] OP_ALU_NOPER = DATA_WIDTH'(OPC_ALU_NOPER)
) (
  input  logic                    CLK,
  input  logic                    RST_n,
  input  logic [DATA_WIDTH-1:0]   RX_DATA,
  input  logic                    RX_VALID,
  output logic [DATA_WIDTH-1:0]   ALU_A,
  output logic [DATA_WIDTH-1:0]   ALU_B,
  output logic [3:0]              ALU_FUN,
  output logic                    ALU_EN,
  input  logic [2*DATA_WIDTH-1:0] ALU_OUT,
  output logic [DATA_WIDTH-1:0]   TX_DATA,
  output logic                    TX_VALID,
  input  logic                    TX_READY,
  output logic                    BUSY,
  output logic                    RX_DROP
);

  state_t     state;
  logic [2:0] lat_cnt;
  logic       tx_hs;
  logic       load_res;
`ifdef ALU_CMD_CTRL_ERR_RESP_EN
  logic       load_err;
`endif

  assign tx_hs = TX_VALID && TX_READY;
  assign BUSY  = (state != ST_IDLE);

  // Capture on the wait cycle where the count would step to zero, which
  // lands the capture ALU_LAT cycles after the ALU_EN cycle.
  assign load_res = (state == ST_ALU_WAIT) && (lat_cnt == 3'd1);

`ifdef ALU_CMD_CTRL_ERR_RESP_EN
  assign load_err = (state == ST_IDLE) && RX_VALID &&
                    (RX_DATA != OP_ALU_OPER) && (RX_DATA != OP_ALU_NOPER);
`endif

  // Bytes arriving while a command is executing or being returned are dropped.
  always_comb begin
    RX_DROP = 1'b0;
    if (RX_VALID) begin
      case (state)
        ST_ALU_REQ, ST_ALU_WAIT, ST_TX_LSB, ST_TX_MSB: RX_DROP = 1'b1;
`ifdef ALU_CMD_CTRL_ERR_RESP_EN
        ST_TX_ERR: RX_DROP = 1'b1;
`endif
        default: RX_DROP = 1'b0;
      endcase
    end
  end

  // Frame FSM with registered operand, function and enable outputs.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state   <= ST_IDLE;
      ALU_A   <= '0;
      ALU_B   <= '0;
      ALU_FUN <= '0;
      ALU_EN  <= 1'b0;
      lat_cnt <= '0;
    end else begin
      ALU_EN <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (RX_VALID) begin
            if (RX_DATA == OP_ALU_OPER) begin
              state <= ST_GET_A;
            end else if (RX_DATA == OP_ALU_NOPER) begin
              state <= ST_GET_FUN;
`ifdef ALU_CMD_CTRL_ERR_RESP_EN
            end else begin
              state <= ST_TX_ERR;
`endif
            end
          end
        end
        ST_GET_A: begin
          if (RX_VALID) begin
            ALU_A <= RX_DATA;
            state <= ST_GET_B;
          end
        end
        ST_GET_B: begin
          if (RX_VALID) begin
            ALU_B <= RX_DATA;
            state <= ST_GET_FUN;
          end
        end
        ST_GET_FUN: begin
          if (RX_VALID) begin
            ALU_FUN <= RX_DATA[3:0];
            ALU_EN  <= 1'b1;
            state   <= ST_ALU_REQ;
          end
        end
        ST_ALU_REQ: begin
          lat_cnt <= 3'(ALU_LAT);
          state   <= ST_ALU_WAIT;
        end
        ST_ALU_WAIT: begin
          if (lat_cnt == 3'd1) begin
            state <= ST_TX_LSB;
          end else begin
            lat_cnt <= lat_cnt - 3'd1;
          end
        end
        ST_TX_LSB: begin
          if (tx_hs) state <= ST_TX_MSB;
        end
        ST_TX_MSB: begin
          if (tx_hs) state <= ST_IDLE;
        end
`ifdef ALU_CMD_CTRL_ERR_RESP_EN
        ST_TX_ERR: begin
          if (tx_hs) state <= ST_IDLE;
        end
`endif
        default: state <= ST_IDLE;
      endcase
    end
  end

  alu_cmd_tx_mux #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_tx_mux (
    .clk      (CLK),
    .rst_n    (RST_n),
    .load_res (load_res),
`ifdef ALU_CMD_CTRL_ERR_RESP_EN
    .load_err (load_err),
`endif
    .res_in   (ALU_OUT),
    .tx_ready (TX_READY),
    .tx_data  (TX_DATA),
    .tx_valid (TX_VALID)
  );

endmodule
